pe_sequencer: RTL and testbench

- Command-driven controller that sequences one PE array.
- Accepts a compute command over a valid/ready handshake.
- Drives the PE control lines (Sel_cu, Sel_cu_go_back, Is_save_cu_out, Sel_adder) through compute, feedback, latch and emit phases.
- Reports completion; sits between the accelerator top-level scheduler and the PE instance.

---
 rtl/pe_seq_pkg.sv | 26 ++
 rtl/pe_seq_timer.sv | 39 +++
 rtl/pe_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_pe_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: shared types and encodings for the PE sequencer.
//   state_e      - sequencer FSM states
//   GB_*         - Sel_cu_go_back encodings driven to the PE
//   AD_*         - Sel_adder encodings driven to the PE
package pe_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPUTE = 3'd1,
        SAVE    = 3'd2,
        LATCH   = 3'd3,
        EMIT    = 3'd4,
        WAIT    = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [1:0] GB_NONE  = 2'b00;
    localparam logic [1:0] GB_PAR   = 2'b01;
    localparam logic [1:0] GB_IN    = 2'b11;
    localparam logic [1:0] GB_LATCH = 2'b10;

    localparam logic [1:0] AD_HOLD = 2'b00;
    localparam logic [1:0] AD_EACH = 2'b01;
    localparam logic [1:0] AD_SUM  = 2'b10;

endpackage

// File: rtl/pe_seq_timer.sv
// pe_seq_timer: loadable down-counter with a zero flag.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (takes priority over dec)
//   load_val  - value to load
//   dec       - decrement by one; saturates at zero
//   zero      - counter currently reads zero
module pe_seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: command-driven controller sequencing one PE array through
// compute passes, inter-pass feedback saves, a latch and an emit phase, with
// an optional wait for the adder tree before reporting completion.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   cmd_valid/ready - command handshake (ready only in IDLE)
//   cmd_op          - CU operation, driven onto Sel_cu during COMPUTE/SAVE
//   cmd_passes      - number of compute passes (0 behaves as 1)
//   cmd_fb_in       - feedback target between passes: 0 = Par, 1 = In
//   cmd_sum         - 0 = per-CU outputs, 1 = adder-tree sum
//   Sel_cu, Sel_cu_go_back, Is_save_cu_out, Sel_adder - PE control lines
//   busy            - high outside IDLE
//   done            - one-cycle completion pulse
//   pass_idx        - current pass index, holds until the next accept
//   abort / aborted - only with PE_SEQ_ABORT_EN defined: abort a running
//                     command; aborted pulses for one cycle instead of done
//
// All outputs are registered: they are decoded from the next state so each
// state's values appear in the cycle that state is occupied.
module pe_sequencer #(
    parameter int CU_LAT    = 2,
    parameter int ADDER_LAT = 3,
    parameter int PASS_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [PASS_W-1:0] cmd_passes,
    input  logic              cmd_fb_in,
    input  logic              cmd_sum,
    output logic [1:0]        Sel_cu,
    output logic [1:0]        Sel_cu_go_back,
    output logic              Is_save_cu_out,
    output logic [1:0]        Sel_adder,
`ifdef PE_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_idx
);

    import pe_seq_pkg::*;

    localparam int MAX_LAT = (CU_LAT > ADDER_LAT) ? CU_LAT : ADDER_LAT;
    localparam int TMR_W   = $clog2(MAX_LAT) + 1;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              fb_q, fb_d;
    logic              sum_q, sum_d;
    logic [PASS_W-1:0] pass_idx_q, pass_idx_d;

    logic [1:0]        sel_cu_q, sel_cu_d;
    logic [1:0]        gb_q, gb_d;
    logic              save_q, save_d;
    logic [1:0]        adder_q, adder_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef PE_SEQ_ABORT_EN
    logic              aborted_q, aborted_d;
`endif

    logic              tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;

    pe_seq_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state and command-field capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        passes_d   = passes_q;
        fb_d       = fb_q;
        sum_d      = sum_q;
        pass_idx_d = pass_idx_q;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        tmr_val    = '0;
`ifdef PE_SEQ_ABORT_EN
        aborted_d  = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    // zero passes normalised to one so the last-pass test is uniform
                    passes_d   = (cmd_passes == '0) ? PASS_W'(1) : cmd_passes;
                    fb_d       = cmd_fb_in;
                    sum_d      = cmd_sum;
                    pass_idx_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(CU_LAT - 1);
                    state_d    = COMPUTE;
                end
            end
            COMPUTE: begin
                // timer holds CU_LAT-1 on entry, so zero marks the last cycle
                if (tmr_zero) begin
                    state_d = (pass_idx_q < passes_q - PASS_W'(1)) ? SAVE : LATCH;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            SAVE: begin
                pass_idx_d = pass_idx_q + PASS_W'(1);
                tmr_load   = 1'b1;
                tmr_val    = TMR_W'(CU_LAT - 1);
                state_d    = COMPUTE;
            end
            LATCH: begin
                state_d = EMIT;
            end
            EMIT: begin
                if (sum_q && (ADDER_LAT > 0)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(ADDER_LAT - 1);
                    state_d  = WAIT;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_d = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef PE_SEQ_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            pass_idx_d = pass_idx_q;
            tmr_load   = 1'b0;
            tmr_dec    = 1'b0;
            aborted_d  = 1'b1;
        end
`endif
    end

    // Output decode from the next state, registered below
    always_comb begin
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        sel_cu_d = ((state_d == COMPUTE) || (state_d == SAVE)) ? op_d : 2'b00;
        save_d   = (state_d == SAVE);
        done_d   = (state_d == DONE);
        gb_d     = GB_NONE;
        if (state_d == SAVE) begin
            gb_d = fb_d ? GB_IN : GB_PAR;
        end else if (state_d == LATCH) begin
            gb_d = GB_LATCH;
        end
        adder_d  = AD_HOLD;
        if (state_d == EMIT) begin
            adder_d = sum_d ? AD_SUM : AD_EACH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            passes_q   <= '0;
            fb_q       <= 1'b0;
            sum_q      <= 1'b0;
            pass_idx_q <= '0;
            sel_cu_q   <= '0;
            gb_q       <= GB_NONE;
            save_q     <= 1'b0;
            adder_q    <= AD_HOLD;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PE_SEQ_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            passes_q   <= passes_d;
            fb_q       <= fb_d;
            sum_q      <= sum_d;
            pass_idx_q <= pass_idx_d;
            sel_cu_q   <= sel_cu_d;
            gb_q       <= gb_d;
            save_q     <= save_d;
            adder_q    <= adder_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PE_SEQ_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign cmd_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign Sel_cu         = sel_cu_q;
    assign Sel_cu_go_back = gb_q;
    assign Is_save_cu_out = save_q;
    assign Sel_adder      = adder_q;
    assign pass_idx       = pass_idx_q;
`ifdef PE_SEQ_ABORT_EN
    assign aborted        = aborted_q;
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: directed bench for pe_sequencer at default parameters
// (CU_LAT=2, ADDER_LAT=3, PASS_W=4). Cycle 0 is the handshake cycle;
// observations are taken 1 time unit after each rising edge.
// Observation vector: {Sel_cu, go_back, save, Sel_adder, done, ready, busy}.
module tb_pe_sequencer;

    typedef logic [9:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_passes;
    logic       cmd_fb_in;
    logic       cmd_sum;
    logic [1:0] Sel_cu;
    logic [1:0] Sel_cu_go_back;
    logic       Is_save_cu_out;
    logic [1:0] Sel_adder;
    logic       busy;
    logic       done;
    logic [3:0] pass_idx;
`ifdef PE_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int nchk = 0;
    int nerr = 0;

    pe_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_passes     (cmd_passes),
        .cmd_fb_in      (cmd_fb_in),
        .cmd_sum        (cmd_sum),
        .Sel_cu         (Sel_cu),
        .Sel_cu_go_back (Sel_cu_go_back),
        .Is_save_cu_out (Is_save_cu_out),
        .Sel_adder      (Sel_adder),
`ifdef PE_SEQ_ABORT_EN
        .abort          (abort),
        .aborted        (aborted),
`endif
        .busy           (busy),
        .done           (done),
        .pass_idx       (pass_idx)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t obs();
        return {Sel_cu, Sel_cu_go_back, Is_save_cu_out, Sel_adder, done, cmd_ready, busy};
    endfunction

    // Offers one command in the current (idle) cycle; returns in cycle 1.
    task automatic issue(input logic [1:0] op, input logic [3:0] np,
                         input logic fb, input logic sm);
        cmd_op     = op;
        cmd_passes = np;
        cmd_fb_in  = fb;
        cmd_sum    = sm;
        cmd_valid  = 1'b1;
        step();
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step();
        step();
        nchk++;
        if (obs() !== 10'b00_00_0_00_0_1_0) begin
            nerr++;
            $display("FAIL reset_outputs got %b exp %b", obs(), 10'b00_00_0_00_0_1_0);
        end
        nchk++;
        if (pass_idx !== 4'd0) begin
            nerr++;
            $display("FAIL reset_pass_idx got %0d exp 0", pass_idx);
        end
        rst = 1'b0;
        step();
        nchk++;
        if (obs() !== 10'b00_00_0_00_0_1_0) begin
            nerr++;
            $display("FAIL idle_after_reset got %b exp %b", obs(), 10'b00_00_0_00_0_1_0);
        end
    endtask

    task automatic test_single_pass;
        vec_t e[6];
        e = '{10'b01_00_0_00_0_0_1, 10'b01_00_0_00_0_0_1, 10'b00_10_0_00_0_0_1,
              10'b00_00_0_01_0_0_1, 10'b00_00_0_00_1_0_1, 10'b00_00_0_00_0_1_0};
        issue(2'b01, 4'd1, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            nchk++;
            if (obs() !== e[c-1]) begin
                nerr++;
                $display("FAIL single_pass cyc %0d got %b exp %b", c, obs(), e[c-1]);
            end
            step();
        end
    endtask

    task automatic test_multi_pass_sum;
        vec_t e[15];
        logic [3:0] ix[15];
        e = '{10'b10_00_0_00_0_0_1, 10'b10_00_0_00_0_0_1, 10'b10_11_1_00_0_0_1,
              10'b10_00_0_00_0_0_1, 10'b10_00_0_00_0_0_1, 10'b10_11_1_00_0_0_1,
              10'b10_00_0_00_0_0_1, 10'b10_00_0_00_0_0_1, 10'b00_10_0_00_0_0_1,
              10'b00_00_0_10_0_0_1, 10'b00_00_0_00_0_0_1, 10'b00_00_0_00_0_0_1,
              10'b00_00_0_00_0_0_1, 10'b00_00_0_00_1_0_1, 10'b00_00_0_00_0_1_0};
        ix = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
               4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
        issue(2'b10, 4'd3, 1'b1, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            nchk++;
            if (obs() !== e[c-1]) begin
                nerr++;
                $display("FAIL multi_pass_sum cyc %0d got %b exp %b", c, obs(), e[c-1]);
            end
            nchk++;
            if (pass_idx !== ix[c-1]) begin
                nerr++;
                $display("FAIL multi_pass_idx cyc %0d got %0d exp %0d", c, pass_idx, ix[c-1]);
            end
            step();
        end
    endtask

    task automatic test_feedback_par;
        vec_t e[9];
        e = '{10'b01_00_0_00_0_0_1, 10'b01_00_0_00_0_0_1, 10'b01_01_1_00_0_0_1,
              10'b01_00_0_00_0_0_1, 10'b01_00_0_00_0_0_1, 10'b00_10_0_00_0_0_1,
              10'b00_00_0_01_0_0_1, 10'b00_00_0_00_1_0_1, 10'b00_00_0_00_0_1_0};
        issue(2'b01, 4'd2, 1'b0, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            nchk++;
            if (obs() !== e[c-1]) begin
                nerr++;
                $display("FAIL feedback_par cyc %0d got %b exp %b", c, obs(), e[c-1]);
            end
            step();
        end
    endtask

    task automatic test_zero_passes;
        vec_t e[6];
        e = '{10'b11_00_0_00_0_0_1, 10'b11_00_0_00_0_0_1, 10'b00_10_0_00_0_0_1,
              10'b00_00_0_01_0_0_1, 10'b00_00_0_00_1_0_1, 10'b00_00_0_00_0_1_0};
        issue(2'b11, 4'd0, 1'b1, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            nchk++;
            if (obs() !== e[c-1]) begin
                nerr++;
                $display("FAIL zero_passes cyc %0d got %b exp %b", c, obs(), e[c-1]);
            end
            nchk++;
            if (pass_idx !== 4'd0) begin
                nerr++;
                $display("FAIL zero_passes_idx cyc %0d got %0d exp 0", c, pass_idx);
            end
            step();
        end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        int a0 = -1;
        int a1 = -1;
        int nd = 0;
        int d0 = -1;
        int d1 = -1;
        cmd_op     = 2'b01;
        cmd_passes = 4'd1;
        cmd_fb_in  = 1'b0;
        cmd_sum    = 1'b0;
        cmd_valid  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (cmd_valid && cmd_ready) begin
                if (acc == 0) a0 = c;
                else a1 = c;
                acc++;
            end
            if (done) begin
                if (nd == 0) d0 = c;
                else d1 = c;
                nd++;
            end
            step();
            if (acc >= 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        nchk++;
        if (acc !== 2) begin
            nerr++;
            $display("FAIL b2b_accepts got %0d exp 2", acc);
        end
        nchk++;
        if ((a0 !== 0) || (a1 !== 6)) begin
            nerr++;
            $display("FAIL b2b_accept_cycles got %0d,%0d exp 0,6", a0, a1);
        end
        nchk++;
        if ((nd !== 2) || (d0 !== 5) || (d1 !== 11)) begin
            nerr++;
            $display("FAIL b2b_done got n=%0d at %0d,%0d exp n=2 at 5,11", nd, d0, d1);
        end
    endtask

    task automatic test_reset_mid_cmd;
        int nd = 0;
        issue(2'b10, 4'd3, 1'b1, 1'b1);
        for (int c = 1; c < 6; c++) step();
        nchk++;
        if ((Is_save_cu_out !== 1'b1) || (pass_idx !== 4'd1)) begin
            nerr++;
            $display("FAIL rst_mid_precond got save=%b idx=%0d exp save=1 idx=1",
                     Is_save_cu_out, pass_idx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nchk++;
        if (obs() !== 10'b00_00_0_00_0_1_0) begin
            nerr++;
            $display("FAIL rst_mid_idle got %b exp %b", obs(), 10'b00_00_0_00_0_1_0);
        end
        for (int c = 0; c < 8; c++) begin
            if (done || busy) nd++;
            step();
        end
        nchk++;
        if (nd !== 0) begin
            nerr++;
            $display("FAIL rst_mid_no_done got %0d busy/done cycles exp 0", nd);
        end
    endtask

`ifdef PE_SEQ_ABORT_EN
    task automatic test_abort;
        int nd = 0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        nchk++;
        if ((aborted !== 1'b0) || (obs() !== 10'b00_00_0_00_0_1_0)) begin
            nerr++;
            $display("FAIL abort_idle got aborted=%b obs=%b exp 0 %b",
                     aborted, obs(), 10'b00_00_0_00_0_1_0);
        end
        issue(2'b01, 4'd1, 1'b0, 1'b1);
        for (int c = 1; c < 5; c++) step();
        nchk++;
        if (obs() !== 10'b00_00_0_00_0_0_1) begin
            nerr++;
            $display("FAIL abort_in_wait got %b exp %b", obs(), 10'b00_00_0_00_0_0_1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        nchk++;
        if ((aborted !== 1'b1) || (obs() !== 10'b00_00_0_00_0_1_0)) begin
            nerr++;
            $display("FAIL abort_pulse got aborted=%b obs=%b exp 1 %b",
                     aborted, obs(), 10'b00_00_0_00_0_1_0);
        end
        step();
        nchk++;
        if (aborted !== 1'b0) begin
            nerr++;
            $display("FAIL abort_one_cycle got %b exp 0", aborted);
        end
        for (int c = 0; c < 6; c++) begin
            if (done) nd++;
            step();
        end
        nchk++;
        if (nd !== 0) begin
            nerr++;
            $display("FAIL abort_no_done got %0d exp 0", nd);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_passes = 4'd0;
        cmd_fb_in  = 1'b0;
        cmd_sum    = 1'b0;
`ifdef PE_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_single_pass();
        test_multi_pass_sum();
        test_feedback_par();
        test_zero_passes();
        test_back_to_back();
        step();
        test_reset_mid_cmd();
`ifdef PE_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
